// File: rtl/aes_pkg.sv
// Shared AES datapath types and state-matrix indexing helpers.
package aes_pkg;
  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  localparam int AES_NB = 4;

  // Column-major FIPS-197 order: s(r,c) lives in byte 4c+r.
  function automatic int aes_byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

  function automatic aes_byte_t aes_get_byte(input aes_state_t s, input int k);
    return s[127 - 8 * k -: 8];
  endfunction
endpackage

// File: rtl/shift_rows.sv
// AES ShiftRows / InvShiftRows stage: one registered result per valid input, 1-cycle latency.
// No backpressure; out holds between valid results and clears asynchronously on rst.
module shift_rows
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       inv,
  input  aes_state_t state,
  output logic       out_valid,
  output aes_state_t out
);

  function automatic aes_state_t shift_fwd(input aes_state_t s);
    aes_state_t t;
    t = '0;
    for (int r = 0; r < AES_NB; r++) begin
      for (int c = 0; c < AES_NB; c++) begin
        t[127 - 8 * aes_byte_idx(r, c) -: 8] =
          aes_get_byte(s, aes_byte_idx(r, (c + r) % AES_NB));
      end
    end
    return t;
  endfunction

  function automatic aes_state_t shift_inv(input aes_state_t s);
    aes_state_t t;
    t = '0;
    for (int r = 0; r < AES_NB; r++) begin
      for (int c = 0; c < AES_NB; c++) begin
        t[127 - 8 * aes_byte_idx(r, c) -: 8] =
          aes_get_byte(s, aes_byte_idx(r, (c - r + AES_NB) % AES_NB));
      end
    end
    return t;
  endfunction

  aes_state_t w_fwd;
  aes_state_t w_inv;
  aes_state_t w_next;
  aes_state_t r_out;
  logic       r_out_valid;

  assign w_fwd  = shift_fwd(state);
  assign w_inv  = shift_inv(state);
  assign w_next = inv ? w_inv : w_fwd;

  // The data register only loads on a valid edge so downstream sees no churn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_next;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_shift_rows.sv
// Randomized and directed bench for shift_rows against a queue-based row-rotation model.
module tb_shift_rows;
  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         inv;
  logic [127:0] state;
  logic         out_valid;
  logic [127:0] out;

  int checks   = 0;
  int failures = 0;

  logic [127:0] m_out;
  logic         m_vld;

  localparam logic [127:0] V1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R1 = 128'h0055aaff4499ee3388dd2277cc1166bb;
  localparam logic [127:0] V2 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] R2 = 128'hfe5445ef7623cd9801abba1089dc3267;
  localparam logic [127:0] ONES = {16{8'h01}};

  shift_rows dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inv       (inv),
    .state     (state),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row is pulled out as a queue of its four column bytes and rotated.
  function automatic logic [127:0] ref_shift(input logic [127:0] s, input bit inverse);
    logic [7:0]   row[$];
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < 4; c++) row.push_back(s[127 - 8 * (4 * c + r) -: 8]);
      for (int n = 0; n < r; n++) begin
        if (!inverse) row.push_back(row.pop_front());
        else          row.push_front(row.pop_back());
      end
      for (int c = 0; c < 4; c++) o[127 - 8 * (4 * c + r) -: 8] = row[c];
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-level model of the registered stage.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = '0;
      m_vld = 1'b0;
    end else begin
      m_vld = in_valid;
      if (in_valid) m_out = ref_shift(state, inv);
    end
  end

  always @(negedge clk) begin
    check("cyc_out_valid", {127'b0, out_valid}, {127'b0, m_vld});
    check("cyc_out", out, m_out);
  end

  task automatic drive(input logic v, input logic i, input logic [127:0] s);
    in_valid = v;
    inv      = i;
    state    = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] x;
    logic [127:0] y;
    rst      = 1'b1;
    in_valid = 1'b0;
    inv      = 1'b0;
    state    = '0;

    // Pin the model itself to hand-computed vectors.
    check("model_fwd_v1", ref_shift(V1, 1'b0), R1);
    check("model_fwd_v2", ref_shift(V2, 1'b0), R2);
    check("model_inv_r1", ref_shift(R1, 1'b1), V1);
    for (int n = 0; n < 1000; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      check("model_roundtrip", ref_shift(ref_shift(x, 1'b0), 1'b1), x);
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, '0);
    check("reset_vld", {127'b0, out_valid}, 128'd0);
    rst = 1'b0;

    // Streaming then hold.
    drive(1'b1, 1'b0, V1);
    check("stream_v1_out", out, R1);
    check("stream_v1_vld", {127'b0, out_valid}, 128'd1);
    drive(1'b1, 1'b0, V2);
    check("stream_v2_out", out, R2);
    check("stream_v2_vld", {127'b0, out_valid}, 128'd1);
    drive(1'b0, 1'b1, {128{1'b1}});
    check("hold_out", out, R2);
    check("hold_vld", {127'b0, out_valid}, 128'd0);

    drive(1'b1, 1'b1, R1);
    check("inv_r1_out", out, V1);

    // Identity rows in both modes.
    drive(1'b1, 1'b0, '0);
    check("ident_zero_fwd", out, '0);
    drive(1'b1, 1'b1, ONES);
    check("ident_ones_inv", out, ONES);
    check("ident_ones_vld", {127'b0, out_valid}, 128'd1);
    drive(1'b1, 1'b0, ONES);
    check("ident_ones_fwd", out, ONES);

    // Asynchronous reset while a result is being presented.
    drive(1'b1, 1'b0, V1);
    check("pre_rst_vld", {127'b0, out_valid}, 128'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", out, '0);
    check("async_rst_vld", {127'b0, out_valid}, 128'd0);
    @(posedge clk);
    #1;
    check("rst_held_out", out, '0);
    check("rst_held_vld", {127'b0, out_valid}, 128'd0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    drive(1'b0, 1'b0, V2);
    check("post_rst_idle_out", out, '0);
    drive(1'b1, 1'b0, V2);
    check("post_rst_first_out", out, R2);

    // Round trips through the DUT itself.
    for (int n = 0; n < 20; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      drive(1'b1, 1'b0, x);
      y = out;
      drive(1'b1, 1'b1, y);
      check("dut_roundtrip", out, x);
    end

    // Random traffic checked by the per-cycle compare.
    for (int n = 0; n < 1000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            {$urandom, $urandom, $urandom, $urandom});
    end
    drive(1'b0, 1'b0, '0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
